// File: rtl/mips_mdu.sv
// mips_mdu -- iterative multiply/divide unit with HI/LO registers.
//
// Executes MULT/MULTU (shift-add) and DIV/DIVU (restoring division) over
// WIDTH calculation cycles plus one sign-fix cycle. MTHI/MTLO write in one
// cycle. o_busy drives the hazard unit so EX holds while an op is in flight.
//
// Ports:
//   i_clk     clock, rising edge
//   i_rst_n   asynchronous active-low reset
//   i_start   issue strobe, sampled on the rising edge
//   i_op      0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
//   i_a       rs operand (multiplicand / dividend / MTHI-MTLO data)
//   i_b       rt operand (multiplier / divisor)
//   i_flush   cancels the in-flight or requested operation
//   o_busy    high while a multiply/divide is in flight (CALC or FIX)
//   o_done    one-cycle pulse after HI/LO receive a new mul/div result
//   o_hi      HI register
//   o_lo      LO register
//   o_state   FSM state (0 IDLE, 1 CALC, 2 FIX) for observation
//
// Handshake: an operation is accepted only when i_start is high, i_flush is
// low and the unit is idle (o_busy low). A start seen while busy is ignored;
// the issuing stage must hold the instruction until o_busy drops.
module mips_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_flush,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic [1:0]       o_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CW-1:0]      r_cnt;
  logic               r_is_div;
  logic               r_sign_a;
  logic               r_sign_b;
  logic               r_b_zero;
  logic [WIDTH-1:0]   r_opnd;    // multiplicand (mul) or divisor (div)
  logic [WIDTH-1:0]   r_raw_a;   // unmodified dividend for divide-by-zero HI
  logic [2*WIDTH-1:0] r_acc;     // mul: {partial, multiplier}; div: {rem, quotient/dividend}
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;

  logic               w_accept;
  logic               w_md_start;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH-1:0]   w_opa;
  logic [WIDTH-1:0]   w_opb;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_mul_acc;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_trial;
  logic [2*WIDTH-1:0] w_div_acc;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  assign w_accept   = (r_state == S_IDLE) && i_start && !i_flush;
  assign w_md_start = w_accept && !i_op[2];

  // op[0] set means unsigned (MULTU/DIVU): take operands raw.
  assign w_abs_a = i_a[WIDTH-1] ? -i_a : i_a;
  assign w_abs_b = i_b[WIDTH-1] ? -i_b : i_b;
  assign w_opa   = i_op[0] ? i_a : w_abs_a;
  assign w_opb   = i_op[0] ? i_b : w_abs_b;

  // Shift-add step: add multiplicand when the current multiplier bit is set,
  // then shift the whole accumulator right, consuming that bit.
  assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_acc = {w_sum, r_acc[WIDTH-1:1]};

  // Restoring step: bring in the next dividend bit, try subtracting the
  // divisor, and keep the difference only when it did not go negative.
  assign w_rem_sh  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_trial   = w_rem_sh - {1'b0, r_opnd};
  assign w_div_acc = w_trial[WIDTH] ? {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                    : {w_trial[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};

  // Sign fix. Sign bits are only latched for signed ops, so unsigned
  // results pass through untouched.
  assign w_prod = (r_sign_a ^ r_sign_b) ? -r_acc : r_acc;

  always_comb begin
    w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
    if (r_is_div) begin
      if (r_b_zero) begin
        w_res_lo = '1;
        w_res_hi = r_raw_a;
      end else begin
        w_res_lo = (r_sign_a ^ r_sign_b) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        w_res_hi = r_sign_a ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
      end
    end
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_md_start) w_next = S_CALC;
      S_CALC: begin
        if (i_flush)            w_next = S_IDLE;
        else if (r_cnt == LAST) w_next = S_FIX;
      end
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode (state only)
  always_comb begin
    o_busy  = (r_state != S_IDLE);
    o_state = r_state;
  end

  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

  // Datapath and architectural registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_b_zero <= 1'b0;
      r_opnd   <= '0;
      r_raw_a  <= '0;
      r_acc    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= (r_state == S_FIX) && !i_flush;
      case (r_state)
        S_IDLE: begin
          if (w_md_start) begin
            r_is_div <= i_op[1];
            r_sign_a <= !i_op[0] && i_a[WIDTH-1];
            r_sign_b <= !i_op[0] && i_b[WIDTH-1];
            r_b_zero <= (i_b == '0);
            r_raw_a  <= i_a;
            r_opnd   <= i_op[1] ? w_opb : w_opa;
            r_acc    <= {{WIDTH{1'b0}}, (i_op[1] ? w_opa : w_opb)};
            r_cnt    <= '0;
          end else if (w_accept && i_op == 3'd4) begin
            r_hi <= i_a;
          end else if (w_accept && i_op == 3'd5) begin
            r_lo <= i_a;
          end
        end
        S_CALC: begin
          if (!i_flush) begin
            r_acc <= r_is_div ? w_div_acc : w_mul_acc;
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_FIX: begin
          if (!i_flush) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mdu.sv
// Directed bench for mips_mdu (WIDTH=32): multiply/divide results, busy/done
// timing, MTHI/MTLO, flush, ignored start and asynchronous reset.
module tb_mips_mdu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [1:0]  state;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  mips_mdu #(.WIDTH(32)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_op    (op),
    .i_a     (a),
    .i_b     (b),
    .i_flush (flush),
    .o_busy  (busy),
    .o_done  (done),
    .o_hi    (hi),
    .o_lo    (lo),
    .o_state (state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single-cycle MTHI/MTLO, checked in the following cycle.
  task automatic mt(input string tag, input logic [2:0] o, input logic [31:0] v);
    op = o; a = v; b = '0; start = 1'b1;
    step();
    start = 1'b0;
    if (o == 3'd4) exp_hi = v;
    else           exp_lo = v;
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
  endtask

  // Issue a mul/div in the current cycle (cycle 0), check busy/done and
  // unchanged HI/LO for cycles 1..33, then the result in cycle 34.
  // inj != 0 pulses a DIVU 9/3 start during that cycle of the operation.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] va,
                        input logic [31:0] vb, input logic [31:0] rhi,
                        input logic [31:0] rlo, input int inj);
    op = o; a = va; b = vb; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 33; c++) begin
      check($sformatf("%s_busy_c%0d", tag, c), busy, 1'b1);
      check($sformatf("%s_done_c%0d", tag, c), done, 1'b0);
      check($sformatf("%s_hold_hi_c%0d", tag, c), hi, exp_hi);
      check($sformatf("%s_hold_lo_c%0d", tag, c), lo, exp_lo);
      if (c == inj) begin
        op = 3'd3; a = 32'd9; b = 32'd3; start = 1'b1;
      end
      step();
      start = 1'b0;
    end
    exp_hi = rhi;
    exp_lo = rlo;
    check({tag, "_done_c34"}, done, 1'b1);
    check({tag, "_busy_c34"}, busy, 1'b0);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; flush = 1'b0;
    exp_hi = '0; exp_lo = '0;
    step();
    step();
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_state", state, 2'd0);
    rst_n = 1'b1;
    step();

    // MULTU max*max
    run_op("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0);
    step();
    check("multu_max_done_c35", done, 1'b0);

    // MULT -3*7, then MTLO issued in the done cycle
    run_op("mult_neg", 3'd0, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 0);
    mt("mtlo", 3'd5, 32'h00001234);

    // Divides, each new op issued in the previous op's done cycle
    run_op("div_neg", 3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    run_op("divu_zero", 3'd3, 32'd7, 32'd0, 32'h00000007, 32'hFFFFFFFF, 0);
    run_op("div_zero_neg", 3'd2, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 0);
    run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0);
    run_op("divu_plain", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 0);
    step();

    // Flush mid-operation
    mt("pre_hi", 3'd4, 32'h000000AA);
    mt("pre_lo", 3'd5, 32'h00000055);
    op = 3'd1; a = 32'd5; b = 32'd5; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      check($sformatf("flush_busy_c%0d", c), busy, 1'b1);
      step();
    end
    check("flush_busy_c10", busy, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_busy_c11", busy, 1'b0);
    check("flush_state_c11", state, 2'd0);
    for (int c = 12; c <= 40; c++) begin
      check($sformatf("flush_nodone_c%0d", c), done, 1'b0);
      check($sformatf("flush_idle_c%0d", c), busy, 1'b0);
      step();
    end
    check("flush_hi", hi, 32'h000000AA);
    check("flush_lo", lo, 32'h00000055);

    // start + flush in IDLE: dropped
    op = 3'd4; a = 32'h0000BEEF; start = 1'b1; flush = 1'b1;
    step();
    start = 1'b0; flush = 1'b0;
    check("sflush_mthi_hi", hi, 32'h000000AA);
    op = 3'd1; a = 32'd3; b = 32'd3; start = 1'b1; flush = 1'b1;
    step();
    start = 1'b0; flush = 1'b0;
    check("sflush_multu_busy", busy, 1'b0);

    // Start pulsed while busy is ignored
    run_op("ign", 3'd1, 32'h00012345, 32'h00010000, 32'h00000001, 32'h23450000, 5);
    for (int c = 35; c <= 75; c++) begin
      step();
      check($sformatf("ign_nodone_c%0d", c), done, 1'b0);
      check($sformatf("ign_idle_c%0d", c), busy, 1'b0);
      check($sformatf("ign_hi_c%0d", c), hi, 32'h00000001);
      check($sformatf("ign_lo_c%0d", c), lo, 32'h23450000);
    end

    // Asynchronous reset in cycle 15 of an operation
    op = 3'd1; a = 32'hFFFFFFFF; b = 32'd2; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 14; c++) step();
    rst_n = 1'b0;
    #1;
    check("rst_mid_hi", hi, 32'h0);
    check("rst_mid_lo", lo, 32'h0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_done", done, 1'b0);
    check("rst_mid_state", state, 2'd0);
    step();
    rst_n = 1'b1;
    exp_hi = '0;
    exp_lo = '0;
    step();
    run_op("post_rst", 3'd1, 32'd3, 32'd4, 32'h0, 32'hC, 0);
    step();
    check("post_rst_done_c35", done, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mips_mdu.md
# mips_mdu

Iterative multiply/divide unit with architectural HI/LO registers, parametrised in datapath width. It sits in the EX stage beside the ALU of the pipelined MIPS core. It executes MULT/MULTU/DIV/DIVU over multiple cycles and MTHI/MTLO in one cycle. Its `busy` output feeds hazard detection so the front end stalls while an operation is in flight.

## Interface
- `WIDTH`, default 32: operand, HI and LO width; must be ≥ 2.
- `clk  in  1`: clock, rising edge.
- `rst  in  1`: reset, asynchronous, active-low.
- `start  in  1`: issue strobe from EX; sampled on the rising edge.
- `op  in  3`: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6/7 are no-ops.
- `a  in  WIDTH`: rs operand (dividend or multiplicand; MTHI/MTLO data).
- `b  in  WIDTH`: rt operand (divisor or multiplier).
- `flush  in  1`: cancels the in-flight or requested operation (branch mispredict or EX flush).
- `busy  out  1`: high while a multi-cycle operation is in flight.
- `done  out  1`: one-cycle pulse when HI/LO hold a new multiply/divide result.
- `hi  out  WIDTH`: HI register (MFHI source).
- `lo  out  WIDTH`: LO register (MFLO source).

## Operation
- **FSM states**
  - IDLE: accepts `start`.
  - CALC: runs WIDTH iterations.
  - FIX: one sign-correction cycle, then commits HI/LO.
  - IDLE → CALC on `start & !flush` with op 0–3. CALC → FIX when the iteration counter reaches WIDTH−1. FIX → IDLE always.
- **Operand capture on the start edge**
  - Signed ops (MULT/DIV) latch |a|, |b| plus the sign bits.
  - Unsigned ops latch raw a and b.
- **Multiply (CALC):** shift-add, one multiplier bit per cycle, into a 2·WIDTH accumulator.
- **Divide (CALC):** restoring division, one quotient bit per cycle, using a WIDTH+1-bit partial remainder.
- **FIX**
  - MULT: negate the product if sign(a) ≠ sign(b).
  - DIV: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
  - Multiply commits {HI,LO} = product. Divide commits LO = quotient, HI = remainder.
- **Divide by zero:** no trap; the full latency still applies. Result is LO = all ones, HI = a (the raw operand). Sign correction is skipped for signed divide.
- **Signed overflow (MIN / −1):** LO = MIN, HI = 0. This falls out of the algorithm and needs no special case.
- **MTHI/MTLO**
  - Accepted only in IDLE with `!flush`.
  - Writes `a` to HI (or LO) at the start edge; the other register is unchanged.
  - No `busy`, no `done`.
- **start while busy:** ignored and no state changes. The hazard unit must hold the instruction in EX.
- **flush**
  - In CALC or FIX: return to IDLE at the next edge. HI/LO keep their pre-operation values and no `done` is produced.
  - In IDLE together with `start`: the start is dropped, including MTHI/MTLO.
- **Arithmetic:** all arithmetic is modulo 2^WIDTH per register. The iteration counter is $clog2(WIDTH) bits.

## Timing
- **Reset values:** `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0, state IDLE, counter 0. Reset takes effect immediately and may occur mid-operation; that operation is discarded.
- **Multiply/divide sequence** (`start` sampled at the end of cycle 0):
  - `busy` is high in cycles 1..WIDTH+1 (WIDTH CALC cycles + 1 FIX cycle).
  - HI/LO update at the end of cycle WIDTH+1.
  - `done` = 1 and `busy` = 0 in cycle WIDTH+2. A new `start` may be accepted in that same cycle.
  - Total latency is WIDTH+2 cycles from start to `done`/result. For WIDTH=32, `done` is in cycle 34.
- **MTHI/MTLO:** the new value is visible on `hi`/`lo` in the cycle after `start`.
- **Flush:** a flush sampled in cycle k ≥ 1 of an operation gives `busy` = 0 in cycle k+1.
- **Outputs:** `hi`/`lo` are register outputs with no combinational path from the inputs. `busy` is decoded from state only.

## Test plan
- **MULTU, WIDTH=32:** a=0xFFFFFFFF, b=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. `busy` high for cycles 1–33, `done` pulse in cycle 34 only.
- **MULT:** a=−3 (0xFFFFFFFD), b=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then MTLO a=0x1234 → LO=0x1234 next cycle, HI unchanged.
- **DIV:** a=−7, b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=7, b=0 → LO=0xFFFFFFFF, HI=0x00000007.
- **DIV overflow:** a=0x80000000, b=0xFFFFFFFF → LO=0x80000000, HI=0x00000000.
- **Flush mid-operation:** preload HI=0xAA, LO=0x55, then start MULTU 5×5 and assert `flush` in cycle 10 → `busy`=0 in cycle 11, no `done`, HI=0xAA, LO=0x55. Separately, start+flush together in IDLE with MTHI → HI unchanged.
- **Ignored start and reset:** pulse `start` (DIVU 9/3) during an in-flight MULTU → the MULTU result commits at the original cycle and no second `done` occurs. Assert `rst`=0 in cycle 15 of a new operation → all outputs are 0 immediately, and the first `start` after release behaves normally.
